// File: rtl/router_pkg.sv
// Shared declarations for the window scheduler: FSM state type, default width
// and the start-time configuration check.
package router_pkg;

  localparam int WIN_ADDR_WIDTH = 6;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, FIN, ERR} win_state_t;

  // A tile is unusable when the kernel is empty, larger than the tile, or the step is zero.
  function automatic logic cfg_rejected(input int k, input int n, input int s);
    return (k == 0) || (k > n) || (s == 0);
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Window origin walker: o_y is the inner dimension, o_x the outer one, plus a
// count of completed windows. o_last flags that no further step fits in the tile.
module window_pos_counter
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH = WIN_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [ADDR_WIDTH-1:0] o_win_idx,
  output logic                  o_last
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]         y_reach, x_reach;
  logic                  y_fits, x_fits;

  // One extra bit keeps origin + step + kernel from wrapping before the compare.
  assign y_reach = CW'(y_q) + CW'(i_stride) + CW'(i_k_size);
  assign x_reach = CW'(x_q) + CW'(i_stride) + CW'(i_k_size);
  assign y_fits  = (y_reach <= CW'(i_i_size));
  assign x_fits  = (x_reach <= CW'(i_i_size));
  assign o_last  = !y_fits && !x_fits;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    idx_d = idx_q;
    if (i_clear) begin
      x_d   = '0;
      y_d   = '0;
      idx_d = '0;
    end else if (i_step) begin
      idx_d = idx_q + ADDR_WIDTH'(1);
      if (y_fits) begin
        y_d = y_q + i_stride;
      end else if (x_fits) begin
        y_d = '0;
        x_d = x_q + i_stride;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q   <= '0;
      y_q   <= '0;
      idx_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      idx_q <= idx_d;
    end
  end

  assign o_o_x     = x_q;
  assign o_o_y     = y_q;
  assign o_win_idx = idx_q;

endmodule

// File: rtl/window_scheduler.sv
// Drives one address generator over every convolution window of a tile.
// Optional feature: define WIN_STRIDE_EN to add the i_stride port (default step is 1).
module window_scheduler
  import router_pkg::*;
#(
  parameter int ADDR_WIDTH = WIN_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
`ifdef WIN_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] i_stride,
`endif
  input  logic                  i_ready,
  input  logic                  i_ag_done,
  output logic                  o_ag_en,
  output logic                  o_ag_clear,
  output logic [ADDR_WIDTH-1:0] o_k_size,
  output logic [ADDR_WIDTH-1:0] o_k_num,
  output logic [ADDR_WIDTH-1:0] o_i_size,
  output logic [ADDR_WIDTH-1:0] o_start_addr,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [ADDR_WIDTH-1:0] o_win_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  win_state_t            state_q;
  logic [ADDR_WIDTH-1:0] k_size_q, k_num_q, i_size_q, start_addr_q;
  logic                  clear_q, done_q, err_q, busy_q;
  logic [ADDR_WIDTH-1:0] stride_in, stride_s;
  logic                  accept, last;

`ifdef WIN_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign stride_in = i_stride;
  assign stride_s  = stride_q;
`else
  assign stride_in = ADDR_WIDTH'(1);
  assign stride_s  = ADDR_WIDTH'(1);
`endif

  assign accept = (state_q == IDLE) && i_start;

  window_pos_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_pos (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (accept),
    .i_step    (state_q == NEXT),
    .i_k_size  (k_size_q),
    .i_i_size  (i_size_q),
    .i_stride  (stride_s),
    .o_o_x     (o_o_x),
    .o_o_y     (o_o_y),
    .o_win_idx (o_win_idx),
    .o_last    (last)
  );

  // Generator completion wins over a stalled downstream: enable drops the cycle done is seen.
  assign o_ag_en = (state_q == RUN) && i_ready && !i_ag_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      k_size_q     <= '0;
      k_num_q      <= '0;
      i_size_q     <= '0;
      start_addr_q <= '0;
`ifdef WIN_STRIDE_EN
      stride_q     <= '0;
`endif
      clear_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            k_size_q     <= i_k_size;
            k_num_q      <= ADDR_WIDTH'(i_k_size * i_k_size);
            i_size_q     <= i_i_size;
            start_addr_q <= i_start_addr;
`ifdef WIN_STRIDE_EN
            stride_q     <= i_stride;
`endif
            busy_q       <= 1'b1;
            if (cfg_rejected(int'(i_k_size), int'(i_i_size), int'(stride_in))) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= LOAD;
              clear_q <= 1'b1;
            end
          end
        end
        LOAD: state_q <= RUN;
        RUN: begin
          if (i_ag_done) begin
            state_q <= NEXT;
          end
        end
        // Outputs are registered, so each pulse is raised on entry to its state.
        NEXT: begin
          if (last) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= LOAD;
            clear_q <= 1'b1;
          end
        end
        FIN, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ag_clear   = clear_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;
  assign o_k_size     = k_size_q;
  assign o_k_num      = k_num_q;
  assign o_i_size     = i_size_q;
  assign o_start_addr = start_addr_q;

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler with a behavioural address generator and a
// window-list model built from the tile geometry; also builds with WIN_STRIDE_EN.
module tb_window_scheduler;

  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, ready = 1'b1, ag_done = 1'b0;
  logic [AW-1:0] k_size = '0, i_size = '0, base_addr = '0;
`ifdef WIN_STRIDE_EN
  logic [AW-1:0] stride = AW'(1);
`endif
  logic ag_en, ag_clear, busy, done, err;
  logic [AW-1:0] k_size_o, k_num_o, i_size_o, start_addr_o, ox, oy, win_idx;

  window_scheduler #(.ADDR_WIDTH(AW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_k_size     (k_size),
    .i_i_size     (i_size),
    .i_start_addr (base_addr),
`ifdef WIN_STRIDE_EN
    .i_stride     (stride),
`endif
    .i_ready      (ready),
    .i_ag_done    (ag_done),
    .o_ag_en      (ag_en),
    .o_ag_clear   (ag_clear),
    .o_k_size     (k_size_o),
    .o_k_num      (k_num_o),
    .o_i_size     (i_size_o),
    .o_start_addr (start_addr_o),
    .o_o_x        (ox),
    .o_o_y        (oy),
    .o_win_idx    (win_idx),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tile model: every window origin in walk order and the addresses each window covers.
  int m_k = 0, m_n = 0, m_base = 0, m_w = 0;
  int exp_ox[$], exp_oy[$], exp_addr[$], act_addr[$];
  bit mon_on = 1'b0, exp_active = 1'b0;
  int n_clear = 0, n_done = 0, n_err = 0, n_en_gap = 0, win_start = 0;
  int first_clear_cyc = -1, done_cyc = -1, err_cyc = -1;
  int c_clear0 = 0, c_done0 = 0, c_err0 = 0, start_cyc = 0;

  task automatic build_model(input int n, input int k, input int s, input int b);
    m_n = n; m_k = k; m_base = b;
    exp_ox.delete(); exp_oy.delete(); exp_addr.delete(); act_addr.delete();
    exp_active = 1'b0;
    win_start = 0;
    if (k >= 1 && k <= n && s >= 1) begin
      for (int x = 0; x + k <= n; x += s) begin
        for (int y = 0; y + k <= n; y += s) begin
          exp_ox.push_back(x);
          exp_oy.push_back(y);
          for (int i = 0; i < k * k; i++)
            exp_addr.push_back((b + (x + i / k) * n + y + i % k) % 64);
        end
      end
    end
    m_w = exp_ox.size();
  endtask

  // Behavioural generator: K*K addressed enables, then one more enable raises done.
  int gen_cnt = 0;
  always @(posedge clk) begin
    if (rst || ag_clear) begin
      gen_cnt <= 0;
      ag_done <= 1'b0;
    end else if (ag_en && !ag_done) begin
      if (gen_cnt == int'(k_size_o) * int'(k_size_o)) begin
        ag_done <= 1'b1;
      end else begin
        act_addr.push_back((int'(start_addr_o) + (int'(ox) + gen_cnt / int'(k_size_o)) * int'(i_size_o)
                            + int'(oy) + gen_cnt % int'(k_size_o)) % 64);
        gen_cnt <= gen_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("ag_en", int'(ag_en), int'(exp_active && ready && !ag_done));
      if (exp_active && !ag_en && !ag_done) n_en_gap++;
      if (exp_active && ag_done) begin
        exp_active = 1'b0;
        check("window_addr_count", act_addr.size() - win_start, m_k * m_k);
      end
      if (ag_clear) begin
        n_clear++;
        if (first_clear_cyc < 0) first_clear_cyc = cyc;
        check("clear_within_tile", int'(exp_ox.size() > 0), 1);
        if (exp_ox.size() > 0) begin
          check("origin_x", int'(ox), exp_ox.pop_front());
          check("origin_y", int'(oy), exp_oy.pop_front());
        end
        check("win_idx_at_load", int'(win_idx), (m_w - exp_ox.size() - 1) % 64);
        check("k_size_o", int'(k_size_o), m_k);
        check("k_num_o", int'(k_num_o), (m_k * m_k) % 64);
        check("i_size_o", int'(i_size_o), m_n);
        check("start_addr_o", int'(start_addr_o), m_base);
        exp_active = 1'b1;
        win_start = act_addr.size();
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("windows_left_at_done", exp_ox.size(), 0);
        check("win_idx_at_done", int'(win_idx), m_w % 64);
        check("busy_at_done", int'(busy), 1);
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  task automatic launch(input int n, input int k, input int b);
    c_clear0 = n_clear; c_done0 = n_done; c_err0 = n_err; n_en_gap = 0;
    first_clear_cyc = -1; done_cyc = -1; err_cyc = -1;
    @(posedge clk); #1;
    k_size = AW'(k); i_size = AW'(n); base_addr = AW'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_end(input int budget, input int stall_win);
    int c = 0;
    bit stalled = 1'b0;
    while (n_done == c_done0 && n_err == c_err0 && c < budget) begin
      @(negedge clk);
      if (stall_win > 0 && !stalled && (n_clear - c_clear0) == stall_win && gen_cnt == 3) begin
        @(posedge clk); #1 ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready = 1'b1;
        stalled = 1'b1;
      end
      c++;
    end
    check("tile_finished_in_budget", int'(c < budget), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_addr_seq(input string tag);
    int bad = 0;
    check({tag, "_addr_count"}, act_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++)
      if (act_addr[i] != exp_addr[i]) bad++;
    check({tag, "_addr_mismatches"}, bad, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_ag_en"}, int'(ag_en), 0);
    check({tag, "_ag_clear"}, int'(ag_clear), 0);
    check({tag, "_o_x"}, int'(ox), 0);
    check({tag, "_o_y"}, int'(oy), 0);
    check({tag, "_win_idx"}, int'(win_idx), 0);
    check({tag, "_k_size"}, int'(k_size_o), 0);
    check({tag, "_k_num"}, int'(k_num_o), 0);
    check({tag, "_i_size"}, int'(i_size_o), 0);
    check({tag, "_start_addr"}, int'(start_addr_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    mon_on = 1'b1;

    // N=4 K=3 S=1: four windows, 13 cycles each, FIN 52 cycles after the load cycle.
    build_model(4, 3, 1, 5);
    check("model_windows", m_w, 4);
    check("model_origin_1", exp_ox[1] * 8 + exp_oy[1], 1);
    check("model_origin_2", exp_ox[2] * 8 + exp_oy[2], 8);
    check("model_origin_3", exp_ox[3] * 8 + exp_oy[3], 9);
    check("model_first_addr", exp_addr[0], 5);
    launch(4, 3, 5);
    wait_end(200, 0);
    check("t1_clears", n_clear - c_clear0, 4);
    check("t1_dones", n_done - c_done0, 1);
    check("t1_errs", n_err - c_err0, 0);
    check("t1_win_idx", int'(win_idx), 4);
    check("t1_k_num", int'(k_num_o), 9);
    check("t1_x_hold", int'(ox), 1);
    check("t1_y_hold", int'(oy), 1);
    check("t1_busy_after", int'(busy), 0);
    check("t1_first_clear_lat", first_clear_cyc - start_cyc, 0);
    check("t1_done_lat", done_cyc - start_cyc, 52);
    check("t1_en_gaps", n_en_gap, 0);
    check_addr_seq("t1");

    // Rejected configurations: kernel larger than tile, and empty kernel.
    build_model(4, 5, 1, 0);
    launch(4, 5, 0);
    wait_end(20, 0);
    check("t2_errs", n_err - c_err0, 1);
    check("t2_err_lat", err_cyc - start_cyc, 0);
    check("t2_clears", n_clear - c_clear0, 0);
    check("t2_dones", n_done - c_done0, 0);
    check("t2_busy_after", int'(busy), 0);
    build_model(4, 0, 1, 0);
    launch(4, 0, 0);
    wait_end(20, 0);
    check("t2b_errs", n_err - c_err0, 1);
    check("t2b_clears", n_clear - c_clear0, 0);

    // Five-cycle downstream stall in window 2.
    build_model(4, 3, 1, 2);
    launch(4, 3, 2);
    wait_end(300, 2);
    check("t3_en_gaps", n_en_gap, 5);
    check("t3_done_lat", done_cyc - start_cyc, 57);
    check("t3_clears", n_clear - c_clear0, 4);
    check_addr_seq("t3");

    // Reset while running window 2, then a clean restart.
    build_model(4, 3, 1, 0);
    launch(4, 3, 0);
    c = 0;
    while ((n_clear - c_clear0) < 2 && c < 100) begin
      @(posedge clk);
      c++;
    end
    check("t4_reached_window2", int'((n_clear - c_clear0) >= 2), 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_active = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_zero("t4_rst");
    build_model(4, 3, 1, 0);
    launch(4, 3, 0);
    wait_end(200, 0);
    check("t4_clears", n_clear - c_clear0, 4);
    check("t4_dones", n_done - c_done0, 1);
    check("t4_win_idx", int'(win_idx), 4);
    check("t4_first_clear_lat", first_clear_cyc - start_cyc, 0);
    check_addr_seq("t4");

    // Starts during RUN and during FIN are dropped.
    build_model(4, 3, 1, 7);
    launch(4, 3, 7);
    c = 0;
    while ((n_clear - c_clear0) < 1 && c < 50) begin
      @(posedge clk);
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    k_size = AW'(1); i_size = AW'(2); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t5_done_seen", int'(done), 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t5_dones", n_done - c_done0, 1);
    check("t5_clears", n_clear - c_clear0, 4);
    check("t5_errs", n_err - c_err0, 0);
    check("t5_busy_after", int'(busy), 0);
    check("t5_win_idx", int'(win_idx), 4);
    check_addr_seq("t5");

`ifdef WIN_STRIDE_EN
    // N=5 K=3 S=2: origins (0,0),(0,2),(2,0),(2,2); then a zero stride is rejected.
    stride = AW'(2);
    build_model(5, 3, 2, 0);
    check("s_model_windows", m_w, 4);
    check("s_model_origin_1", exp_ox[1] * 8 + exp_oy[1], 2);
    check("s_model_origin_2", exp_ox[2] * 8 + exp_oy[2], 16);
    check("s_model_origin_3", exp_ox[3] * 8 + exp_oy[3], 18);
    launch(5, 3, 0);
    wait_end(200, 0);
    check("s_clears", n_clear - c_clear0, 4);
    check("s_dones", n_done - c_done0, 1);
    check("s_win_idx", int'(win_idx), 4);
    check("s_x_hold", int'(ox), 2);
    check("s_y_hold", int'(oy), 2);
    check_addr_seq("s");
    stride = AW'(0);
    build_model(5, 3, 0, 0);
    launch(5, 3, 0);
    wait_end(20, 0);
    check("s0_errs", n_err - c_err0, 1);
    check("s0_clears", n_clear - c_clear0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
